// File: rtl/otter_regfile_sb.sv
// Register file with pending-write scoreboard and a reset-clear sequencer.
// Two combinational read ports, one writeback port, one issue port.

module otter_regfile_rdport #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            ready,
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] rf_q,
    input  logic            pend_q,
    input  logic            we,
    input  logic [AW-1:0]   dest,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            busy
);
    logic hit;

    assign hit = (BYPASS != 0) && we && (dest == raddr);

    always_comb begin
        dout = '0;
        busy = 1'b0;
        if (ready && raddr != '0) begin
            if (hit) begin
                dout = din;
            end else begin
                dout = rf_q;
                busy = pend_q;
            end
        end
    end
endmodule

module otter_regfile_sb #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   READ1,
    input  logic [AW-1:0]   READ2,
    output logic [XLEN-1:0] OUT1,
    output logic [XLEN-1:0] OUT2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic            WRITE_ENABLE,
    input  logic [AW-1:0]   DEST_REG,
    input  logic [XLEN-1:0] DIN,
    input  logic            ISSUE_EN,
    input  logic [AW-1:0]   ISSUE_REG,
    output logic            READY
);
    localparam int NPORTS = 2;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                       state, nstate;
    logic [AW-1:0]                cnt, ncnt;
    logic                         clr_we, wr_hit, iss_hit;
    logic [XLEN-1:0]              rf [NREGS];
    logic [NREGS-1:0]             pend;
    logic [NPORTS-1:0][AW-1:0]    raddr;
    logic [NPORTS-1:0][XLEN-1:0]  dout;
    logic [NPORTS-1:0]            busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        if (state == CLEAR) begin
            if (cnt == AW'(NREGS - 1)) nstate = RUN;
            else                       ncnt   = cnt + AW'(1);
        end
    end

    always_comb begin
        READY  = (state == RUN);
        clr_we = (state == CLEAR) && !RST;
    end

    assign wr_hit  = READY && !RST && WRITE_ENABLE && (DEST_REG != '0);
    assign iss_hit = READY && !RST && ISSUE_EN && (ISSUE_REG != '0);

    // Register 0 is never stored; the read ports mask it to zero.
    always_ff @(posedge CLK) begin
        if (clr_we)      rf[cnt]      <= '0;
        else if (wr_hit) rf[DEST_REG] <= DIN;
    end

    // Issue beats writeback on the same register: a newer producer is in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend <= '0;
        end else begin
            pend[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (iss_hit && ISSUE_REG == AW'(i))     pend[i] <= 1'b1;
                else if (wr_hit && DEST_REG == AW'(i)) pend[i] <= 1'b0;
            end
        end
    end

    assign raddr[0] = READ1;
    assign raddr[1] = READ2;

    for (genvar g = 0; g < NPORTS; g++) begin : g_rd
        otter_regfile_rdport #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rd (
            .ready  (READY),
            .raddr  (raddr[g]),
            .rf_q   (rf[raddr[g]]),
            .pend_q (pend[raddr[g]]),
            .we     (WRITE_ENABLE),
            .dest   (DEST_REG),
            .din    (DIN),
            .dout   (dout[g]),
            .busy   (busy[g])
        );
    end

    assign OUT1  = dout[0];
    assign OUT2  = dout[1];
    assign BUSY1 = busy[0];
    assign BUSY2 = busy[1];
endmodule
